// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC core.
//   - cordic_state_e : controller states (idle, iterating, result held)
//   - MODE_ROT/VEC   : operation select (drive z to 0 / drive y to 0)
//   - ATAN_TABLE     : atan(2^-i) as a 32-bit binary angle (2^31 LSB = pi)
//   - atan_angle()   : table entry rescaled to a narrower angle width, rounded
//   - K_GAIN         : CORDIC magnitude growth, for callers pre-scaling operands
package cordic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } cordic_state_e;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam real K_GAIN = 1.646760258121;

    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // Rescale entry idx to a width-bit angle (2^(width-1) LSB = pi), round half up.
    // All entries are positive, so a logical shift equals the arithmetic one.
    function automatic logic [31:0] atan_angle(input int unsigned width, input logic [4:0] idx);
        logic [32:0]  rounded;
        int unsigned  sh;
        sh = 32 - width;
        if (sh == 0) begin
            return ATAN_TABLE[idx];
        end
        rounded = {1'b0, ATAN_TABLE[idx]} + (33'd1 << (sh - 1));
        return 32'(rounded >> sh);
    endfunction

endpackage

// File: rtl/cordic_iter_core_if.sv
// Operand / result handshake bundle for cordic_iter_core.
//   in_valid/in_ready   : operand handshake (mode, x_in, y_in, z_in)
//   out_valid/out_ready : result handshake (x_out, y_out, z_out)
//   busy                : core is not idle
// master = producer/consumer side, slave = the core.
interface cordic_iter_core_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] z_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] z_out;
    logic                    busy;

    modport master (
        output in_valid, mode, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, busy
    );

    modport slave (
        input  in_valid, mode, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, busy
    );

endinterface

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation.
//   x_i, y_i : WIDTH+2-bit signed vector (headroom for gain and negation)
//   z_i      : WIDTH-bit binary angle, wraps mod 2*pi
//   iter_i   : iteration index i (shift amount and atan table index)
//   mode_i   : MODE_ROT steers on sign of z, MODE_VEC steers on sign of y
//   x_o, y_o, z_o : rotated vector and updated angle
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CntW  = 5
) (
    input  logic signed [WIDTH+1:0] x_i,
    input  logic signed [WIDTH+1:0] y_i,
    input  logic signed [WIDTH-1:0] z_i,
    input  logic        [CntW-1:0]  iter_i,
    input  logic                    mode_i,
    output logic signed [WIDTH+1:0] x_o,
    output logic signed [WIDTH+1:0] y_o,
    output logic signed [WIDTH-1:0] z_o
);

    logic                    sigma_pos;
    logic signed [WIDTH+1:0] x_sh;
    logic signed [WIDTH+1:0] y_sh;
    logic signed [WIDTH-1:0] atan_w;

    always_comb begin
        // sigma = +1: rotate counter-clockwise by atan(2^-i) and subtract it from z
        sigma_pos = (mode_i == MODE_VEC) ? y_i[WIDTH+1] : ~z_i[WIDTH-1];
        x_sh      = x_i >>> iter_i;
        y_sh      = y_i >>> iter_i;
        atan_w    = WIDTH'(atan_angle(WIDTH, 5'(iter_i)));
        if (sigma_pos) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_w;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_w;
        end
    end

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine, one micro-rotation per clock, rotation and vectoring modes.
// Quadrant pre-rotation at accept extends the range to +/-pi; x/y results saturate to
// WIDTH bits, z wraps. No gain compensation (magnitude grows by K_GAIN).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of cordic_iter_core_if (operand/result handshakes, busy)
module cordic_iter_core
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 14
) (
    input logic               clk,
    input logic               rst_n,
    cordic_iter_core_if.slave bus
);

    localparam int unsigned        CntW     = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]    LastIter = CntW'(ITER - 1);

    cordic_state_e           state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    mode_q, mode_d;
    logic signed [WIDTH+1:0] x_q, x_d;
    logic signed [WIDTH+1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic signed [WIDTH-1:0] x_out_q, x_out_d;
    logic signed [WIDTH-1:0] y_out_q, y_out_d;
    logic signed [WIDTH-1:0] z_out_q, z_out_d;

    logic signed [WIDTH+1:0] x_nxt;
    logic signed [WIDTH+1:0] y_nxt;
    logic signed [WIDTH-1:0] z_nxt;
    logic signed [WIDTH+1:0] x_ext;
    logic signed [WIDTH+1:0] y_ext;
    logic                    pre_flip;

    // Clamp to WIDTH bits: in range iff the top three bits agree.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH+1:0] v);
        if (v[WIDTH+1:WIDTH-1] == 3'b000 || v[WIDTH+1:WIDTH-1] == 3'b111) begin
            return v[WIDTH-1:0];
        end else if (v[WIDTH+1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    cordic_microrot #(
        .WIDTH (WIDTH),
        .CntW  (CntW)
    ) u_microrot (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .iter_i (cnt_q),
        .mode_i (mode_q),
        .x_o    (x_nxt),
        .y_o    (y_nxt),
        .z_o    (z_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;

        x_ext = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
        y_ext = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
        // Rotation: |z| beyond pi/2 (top two bits differ). Vectoring: x in left half-plane.
        // Either way the fix is a half turn: negate x/y and add pi (flip z MSB).
        pre_flip = (bus.mode == MODE_ROT) ? (bus.z_in[WIDTH-1] ^ bus.z_in[WIDTH-2])
                                          : bus.x_in[WIDTH-1];

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mode_d  = bus.mode;
                    x_d     = pre_flip ? -x_ext : x_ext;
                    y_d     = pre_flip ? -y_ext : y_ext;
                    z_d     = bus.z_in ^ {pre_flip, {(WIDTH-1){1'b0}}};
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                x_d   = x_nxt;
                y_d   = y_nxt;
                z_d   = z_nxt;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    // Register the final iteration's result directly into the output stage
                    state_d = StDone;
                    cnt_d   = '0;
                    x_out_d = saturate(x_nxt);
                    y_out_d = saturate(y_nxt);
                    z_out_d = z_nxt;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= MODE_ROT;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.x_out     = x_out_q;
    assign bus.y_out     = y_out_q;
    assign bus.z_out     = z_out_q;

endmodule

// File: doc/cordic_iter_core.md
# cordic_iter_core

Parametrised iterative CORDIC engine that executes one micro-rotation per clock and supports both rotation and vectoring modes. It adds quadrant pre-rotation so the full ±π angle range is accepted, saturates its outputs, and uses a valid/ready handshake on both input and output. It sits behind the TinyTapeout top wrapper, where clk = io_in[0], and it replaces the fixed-width, rotation-only datapath.

## Interface
- WIDTH, 16: signed width of x/y/z in and out; 8..32.
- ITER, 14: micro-rotations per operation; 4..WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  core idle, can accept operands.
- mode  in  1  0 = rotation (drive z→0), 1 = vectoring (drive y→0); sampled at accept.
- x_in, y_in  in  WIDTH  signed vector.
- z_in  in  WIDTH  binary angle; 2^(WIDTH-1) LSB = π, wraps mod 2π.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- x_out, y_out, z_out  out  WIDTH  result. x/y are saturated; z wraps.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready = 1.
  - On in_valid && in_ready: latch mode and load internal x, y (WIDTH+2 bits, sign-extended) and z with pre-rotation applied.
  - Set i = 0 and go to RUN.
- Pre-rotation, rotation mode: if z ∉ [−π/2, π/2] (top two bits of z differ), set x = −x, y = −y, z = z − π (mod 2π).
- Pre-rotation, vectoring mode: if x < 0, set x = −x, y = −y, z = z + π (mod 2π).
- RUN: each cycle performs one micro-rotation.
  - σ = +1 if (rotation: z ≥ 0; vectoring: y < 0), else σ = −1.
  - x' = x − σ·(y >>> i); y' = y + σ·(x >>> i); z' = z − σ·ATAN[i].
  - Shifts are arithmetic. ATAN[i] = round(atan(2^−i)·2^(WIDTH−1)/π).
  - i increments each cycle. After iteration i = ITER−1, go to DONE.
- DONE: out_valid = 1.
  - x_out/y_out = internal value saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; z_out = z.
  - Outputs are registered and hold stable until out_ready. On out_valid && out_ready, go to IDLE.
- No gain compensation: x/y magnitude grows by K ≈ 1.6468. Callers pre-scale.
- Negation of the most-negative value wraps in WIDTH+2 bits, where it is representable, so there is no overflow.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, x_out = y_out = z_out = 0, state = IDLE, i = 0.
- Latency: accept at edge E0; out_valid rises after edge E0+ITER; results are visible ITER cycles after the accept edge.
- Throughput: one operation per ITER+2 cycles minimum.
  - in_ready returns 1 in the cycle after the output handshake.
  - There is no same-cycle turnaround.
- in_ready is 0 throughout RUN and DONE. in_valid is ignored there; operands must be held by the producer.
- Backpressure: in DONE with out_ready = 0, all outputs stay frozen indefinitely.
- rst_n asserted at any point, including mid-RUN, immediately clears to reset values. After release, the first accept is possible on the first edge.
- mode and operands only matter on the accept edge.

## Structure
- Package cordic_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - mode constants (MODE_ROT = 0, MODE_VEC = 1);
  - ATAN_TABLE: 32 entries × 32-bit binary angle, sliced to WIDTH by arithmetic right shift with rounding;
  - K_GAIN constant for benches.
- Sub-module cordic_microrot: a purely combinational single iteration taking x, y, z, i, mode and returning x', y', z'. The top holds the FSM, counter, pre-rotation, saturation and output registers.

## Test plan
WIDTH = 16, ITER = 14, tolerance ±4 LSB:
- Rotation, x=10000, y=0, z=0 → x_out ≈ 16468, y_out ≈ 0, z_out ≈ 0; out_valid rises exactly 14 cycles after accept.
- Rotation, x=10000, y=0, z=24576 (135°, pre-rotation path) → x_out ≈ −11645, y_out ≈ 11645, z_out ≈ 0.
- Vectoring, x=3000, y=4000 → x_out ≈ 8234, y_out ≈ 0, z_out ≈ 9672; then vectoring x=−5000, y=0 → x_out ≈ 8234, z_out ≈ −32768 (±π).
- Saturation: rotation, x = y = 30000, z=0 → x_out = y_out = 32767.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, busy=1; raise out_ready → next cycle in_ready=1.
- Reset during RUN at i=5 → out_valid=0, in_ready=1 immediately; next operation (first case) returns the correct result.
